// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences the shared ALU, memory port and IR over 3-5 cycles per
// instruction and derives the PC load enable from pcWrite/branch/zero.
// All outputs are combinational from state, reset, memReady, opcode, zero.
module multicycle_controller #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           memReady,
  output logic           iorD,
  output logic           irWrite,
  output logic           memWrite,
  output logic           regWrite,
  output logic           regDst,
  output logic           memToReg,
  output logic           aluSrcA,
  output logic [1:0]     aluSrcB,
  output logic [1:0]     aluOp,
  output logic [1:0]     pcSrc,
  output logic           pcEn,
  output logic           instrDone,
  output logic           illegalOp,
  output logic [3:0]     state
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } stateT;

  // Full control word for one cycle; pcWrite/branchEq/branchNe stay internal
  // and are folded into pcEn.
  typedef struct packed {
    logic       iorD;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic       instrDone;
    logic       illegalOp;
  } ctrlT;

  stateT curState, nextState;
  ctrlT  ctrl;

  logic isRtype, isLw, isSw, isBeq, isBne, isAddi, isJ, isLegal;

  // Opcode decode; only consumed in DECODE, MEMADR and BRANCH.
  always_comb begin
    isRtype = (opcode == OP_RTYPE);
    isLw    = (opcode == OP_LW);
    isSw    = (opcode == OP_SW);
    isBeq   = (opcode == OP_BEQ);
    isBne   = (opcode == OP_BNE);
    isAddi  = (opcode == OP_ADDI);
    isJ     = (opcode == OP_J);
    isLegal = isRtype | isLw | isSw | isBeq | isBne | isAddi | isJ;
  end

  // State register: the only storage in the block.
  always_ff @(posedge clk) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  // Next-state logic; unreachable encodings fall back to FETCH.
  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:   nextState = memReady ? DECODE : FETCH;
      DECODE: begin
        if (isLw | isSw)        nextState = MEMADR;
        else if (isRtype)       nextState = EXECUTE;
        else if (isBeq | isBne) nextState = BRANCH;
        else if (isAddi)        nextState = ADDIEX;
        else if (isJ)           nextState = JUMP;
        else                    nextState = FETCH;
      end
      // IR is stable here, so the opcode is still lw or sw; anything else
      // would be a corrupted IR and is abandoned.
      MEMADR: begin
        if (isLw)      nextState = MEMRD;
        else if (isSw) nextState = MEMWR;
        else           nextState = FETCH;
      end
      MEMRD:   nextState = memReady ? MEMWB : MEMRD;
      MEMWR:   nextState = memReady ? FETCH : MEMWR;
      EXECUTE: nextState = ALUWB;
      ADDIEX:  nextState = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // Moore control word per state, with memReady gating the memory-side
  // enables; reset clears everything including mux selects.
  always_comb begin
    ctrl = '0;
    case (curState)
      FETCH: begin
        ctrl.aluSrcB = 2'b01;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      DECODE: begin
        ctrl.aluSrcB   = 2'b11;
        ctrl.illegalOp = ~isLegal;
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
      end
      MEMRD: ctrl.iorD = 1'b1;
      MEMWB: begin
        ctrl.memToReg  = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      MEMWR: begin
        ctrl.iorD      = 1'b1;
        ctrl.memWrite  = memReady;
        ctrl.instrDone = memReady;
      end
      EXECUTE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = 2'b10;
      end
      ALUWB: begin
        ctrl.regDst    = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluOp     = 2'b01;
        ctrl.pcSrc     = 2'b01;
        ctrl.instrDone = 1'b1;
        ctrl.branchEq  = isBeq;
        ctrl.branchNe  = isBne;
      end
      ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
      end
      ADDIWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      JUMP: begin
        ctrl.pcSrc     = 2'b10;
        ctrl.pcWrite   = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) ctrl = '0;
  end

  // Output mapping; pcEn combines unconditional and conditional PC loads.
  always_comb begin
    iorD      = ctrl.iorD;
    irWrite   = ctrl.irWrite;
    memWrite  = ctrl.memWrite;
    regWrite  = ctrl.regWrite;
    regDst    = ctrl.regDst;
    memToReg  = ctrl.memToReg;
    aluSrcA   = ctrl.aluSrcA;
    aluSrcB   = ctrl.aluSrcB;
    aluOp     = ctrl.aluOp;
    pcSrc     = ctrl.pcSrc;
    instrDone = ctrl.instrDone;
    illegalOp = ctrl.illegalOp;
    pcEn      = ctrl.pcWrite | (ctrl.branchEq & zero) | (ctrl.branchNe & ~zero);
    state     = curState;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions from
// the test plan followed by randomized instruction streams, checked against
// an instruction-level model (expected state path plus per-instruction
// enable counts).
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECUTE = 4'd6,
    S_ALUWB = 4'd7, S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10,
    S_JUMP = 4'd11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic       clk, reset, zero, memReady;
  logic [5:0] opcode;
  logic       iorD, irWrite, memWrite, regWrite, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic       pcEn, instrDone, illegalOp;
  logic [3:0] state;

  int nChecks = 0;
  int nFail   = 0;

  multicycle_controller #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .iorD(iorD), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSrc(pcSrc), .pcEn(pcEn), .instrDone(instrDone),
    .illegalOp(illegalOp), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs away from the active edge, then let the
  // combinational outputs settle before they are sampled.
  task automatic step(input logic rst, input logic mr, input logic z, input logic [5:0] op);
    @(negedge clk);
    reset = rst; memReady = mr; zero = z; opcode = op;
    #1;
  endtask

  function automatic logic isLegalOp(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction

  // Run one instruction from its first FETCH cycle to its last cycle.
  // wF / wM are memReady-low wait cycles in FETCH and in MEMRD/MEMWR;
  // zBr is the ALU zero flag presented during a branch.
  task automatic runInstr(input logic [5:0] op, input int wF, input int wM, input logic zBr);
    logic [3:0] expSt[$];
    logic       expMr[$];
    logic       expZ[$];
    int cIr = 0, cMw = 0, cRw = 0, cPc = 0, cDone = 0, cIll = 0, cFunct = 0;
    int eRw, eMw, ePc, eDone, eIll, eFunct;
    for (int i = 0; i < wF; i++) begin expSt.push_back(S_FETCH); expMr.push_back(1'b0); end
    expSt.push_back(S_FETCH);  expMr.push_back(1'b1);
    expSt.push_back(S_DECODE); expMr.push_back(1'($urandom));
    case (op)
      OP_LW: begin
        expSt.push_back(S_MEMADR); expMr.push_back(1'($urandom));
        for (int i = 0; i < wM; i++) begin expSt.push_back(S_MEMRD); expMr.push_back(1'b0); end
        expSt.push_back(S_MEMRD); expMr.push_back(1'b1);
        expSt.push_back(S_MEMWB); expMr.push_back(1'($urandom));
      end
      OP_SW: begin
        expSt.push_back(S_MEMADR); expMr.push_back(1'($urandom));
        for (int i = 0; i < wM; i++) begin expSt.push_back(S_MEMWR); expMr.push_back(1'b0); end
        expSt.push_back(S_MEMWR); expMr.push_back(1'b1);
      end
      OP_R: begin
        expSt.push_back(S_EXECUTE); expMr.push_back(1'($urandom));
        expSt.push_back(S_ALUWB);   expMr.push_back(1'($urandom));
      end
      OP_ADDI: begin
        expSt.push_back(S_ADDIEX); expMr.push_back(1'($urandom));
        expSt.push_back(S_ADDIWB); expMr.push_back(1'($urandom));
      end
      OP_BEQ, OP_BNE: begin expSt.push_back(S_BRANCH); expMr.push_back(1'($urandom)); end
      OP_J:           begin expSt.push_back(S_JUMP);   expMr.push_back(1'($urandom)); end
      default: ;
    endcase
    foreach (expSt[k]) expZ.push_back(expSt[k] == S_BRANCH ? zBr : 1'($urandom));

    foreach (expSt[k]) begin
      // During FETCH the IR still holds an old value: feed garbage.
      step(1'b0, expMr[k], expZ[k], (expSt[k] == S_FETCH) ? 6'($urandom) : op);
      check("state", 32'(state), 32'(expSt[k]));
      cIr += int'(irWrite); cMw += int'(memWrite); cRw += int'(regWrite);
      cPc += int'(pcEn); cDone += int'(instrDone); cIll += int'(illegalOp);
      cFunct += int'(aluOp == 2'b10);
      case (expSt[k])
        S_ALUWB:  check("regDst_rtype", 32'(regDst), 32'd1);
        S_ADDIWB: check("regDst_addi", 32'(regDst), 32'd0);
        S_MEMWB:  check("memToReg_lw", 32'(memToReg), 32'd1);
        S_JUMP:   check("pcSrc_j", 32'(pcSrc), 32'd2);
        S_BRANCH: check("branch_pcSrc_aluOp", 32'({pcSrc, aluOp}), 32'b0101);
        default: ;
      endcase
    end

    eRw    = (op == OP_LW || op == OP_R || op == OP_ADDI) ? 1 : 0;
    eMw    = (op == OP_SW) ? 1 : 0;
    eDone  = isLegalOp(op) ? 1 : 0;
    eIll   = isLegalOp(op) ? 0 : 1;
    eFunct = (op == OP_R) ? 1 : 0;
    ePc    = 1 + ((op == OP_J) ? 1 : 0) + ((op == OP_BEQ && zBr) ? 1 : 0)
               + ((op == OP_BNE && !zBr) ? 1 : 0);
    check("irWrite_count", 32'(cIr), 32'd1);
    check("memWrite_count", 32'(cMw), 32'(eMw));
    check("regWrite_count", 32'(cRw), 32'(eRw));
    check("pcEn_count", 32'(cPc), 32'(ePc));
    check("instrDone_count", 32'(cDone), 32'(eDone));
    check("illegalOp_count", 32'(cIll), 32'(eIll));
    check("aluOpFunct_count", 32'(cFunct), 32'(eFunct));
  endtask

  logic [5:0] legalOps[7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

  initial begin
    logic [5:0] rop;
    reset = 1'b1; memReady = 1'b0; zero = 1'b0; opcode = 6'd0;

    // Reset: enables held low even with memReady high.
    step(1'b1, 1'b1, 1'b1, OP_J);
    check("rst_enables", 32'({irWrite, memWrite, regWrite, pcEn, instrDone, illegalOp}), 32'd0);
    step(1'b1, 1'b1, 1'b0, 6'b111111);
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_enables2", 32'({irWrite, memWrite, regWrite, pcEn, instrDone, illegalOp}), 32'd0);
    check("rst_selects", 32'({iorD, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSrc}), 32'd0);

    // Directed instructions.
    runInstr(OP_LW, 0, 0, 1'b0);
    runInstr(OP_SW, 0, 2, 1'b0);
    runInstr(OP_BEQ, 0, 0, 1'b1);
    runInstr(OP_BEQ, 0, 0, 1'b0);
    runInstr(OP_BNE, 0, 0, 1'b1);
    runInstr(OP_BNE, 0, 0, 1'b0);
    runInstr(OP_R, 0, 0, 1'b0);
    runInstr(OP_ADDI, 0, 0, 1'b0);
    runInstr(6'b111111, 0, 0, 1'b0);
    runInstr(OP_LW, 2, 1, 1'b1);

    // Reset in the middle of an lw stalled in MEMRD.
    step(1'b0, 1'b1, 1'b0, 6'($urandom));
    check("mid_fetch", 32'(state), 32'(S_FETCH));
    step(1'b0, 1'b0, 1'b0, OP_LW);
    check("mid_decode", 32'(state), 32'(S_DECODE));
    step(1'b0, 1'b0, 1'b0, OP_LW);
    check("mid_memadr", 32'(state), 32'(S_MEMADR));
    step(1'b0, 1'b0, 1'b0, OP_LW);
    check("mid_memrd", 32'(state), 32'(S_MEMRD));
    check("mid_memrd_rw", 32'(regWrite), 32'd0);
    step(1'b1, 1'b1, 1'b0, OP_LW);
    check("mid_rst_enables", 32'({irWrite, memWrite, regWrite, pcEn, instrDone, illegalOp}), 32'd0);
    runInstr(OP_J, 0, 0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) begin
        rop = 6'b111111;
        for (int t = 0; t < 64; t++) begin
          rop = 6'($urandom);
          if (!isLegalOp(rop)) break;
        end
        if (isLegalOp(rop)) rop = 6'b111110;
      end else begin
        rop = legalOps[$urandom_range(6)];
      end
      runInstr(rop, $urandom_range(2), $urandom_range(3), 1'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 6'($urandom));
    check("final_fetch", 32'(state), 32'(S_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control state machine for the multicycle MIPS datapath. It sequences one shared ALU, one shared memory port and the instruction register across 3–5 cycles per instruction. It also produces the PC write-enable by combining the unconditional PC write with the branch and ALU-zero condition. It sits beside the datapath, takes `opcode` from the instruction register and `zero` from the ALU, and drives every datapath mux select and write enable.

## Interface
Parameters:
- `OPW`, default 6: opcode width.

Ports:
- `clk`, input, 1 bit: rising-edge clock.
- `reset`, input, 1 bit: synchronous, active-high.
- `opcode`, input, OPW bits: instr[31:26], taken from the IR output.
- `zero`, input, 1 bit: ALU result == 0.
- `memReady`, input, 1 bit: memory access completes this cycle.
- `iorD`, output, 1 bit: address mux select (0 = PC, 1 = ALUOut).
- `irWrite`, output, 1 bit: IR load enable.
- `memWrite`, output, 1 bit: memory write enable.
- `regWrite`, output, 1 bit: register file write enable.
- `regDst`, output, 1 bit: write register select (0 = rt, 1 = rd).
- `memToReg`, output, 1 bit: writeback data select (0 = ALUOut, 1 = MDR).
- `aluSrcA`, output, 1 bit: ALU A select (0 = PC, 1 = A).
- `aluSrcB`, output, 2 bits: ALU B select (00 = B, 01 = 4, 10 = signext, 11 = signext<<2).
- `aluOp`, output, 2 bits: to ALU decoder (00 = add, 01 = sub, 10 = funct).
- `pcSrc`, output, 2 bits: next-PC select (00 = ALU, 01 = ALUOut, 10 = jump target).
- `pcEn`, output, 1 bit: PC load enable.
- `instrDone`, output, 1 bit: 1-cycle pulse in the final state of each instruction.
- `illegalOp`, output, 1 bit: 1-cycle pulse on an unsupported opcode.
- `state`, output, 4 bits: current state, for debug and verification.

## Operation
- Decoded opcodes:
  - R-type: 000000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - bne: 000101
  - addi: 001000
  - j: 000010
- States and their encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 are unreachable; if entered, go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when memReady; otherwise stay in FETCH.
  - DECODE: lw or sw → MEMADR; R-type → EXECUTE; beq or bne → BRANCH; addi → ADDIEX; j → JUMP; any other opcode → FETCH with illegalOp = 1.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB when memReady; otherwise stay.
  - MEMWR → FETCH when memReady; otherwise stay.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP each → FETCH.
- Moore outputs per state (any output not listed is 0):
  - FETCH: aluSrcB = 01; irWrite = memReady; internal pcWrite = memReady.
  - DECODE: aluSrcB = 11.
  - MEMADR: aluSrcA = 1, aluSrcB = 10.
  - MEMRD: iorD = 1.
  - MEMWB: memToReg = 1, regWrite = 1, instrDone = 1.
  - MEMWR: iorD = 1, memWrite = memReady, instrDone = memReady.
  - EXECUTE: aluSrcA = 1, aluOp = 10.
  - ALUWB: regDst = 1, regWrite = 1, instrDone = 1.
  - BRANCH: aluSrcA = 1, aluOp = 01, pcSrc = 01, instrDone = 1. Internal branchEq = (opcode == beq); internal branchNe = (opcode == bne).
  - ADDIEX: aluSrcA = 1, aluSrcB = 10.
  - ADDIWB: regWrite = 1, instrDone = 1.
  - JUMP: pcSrc = 10, pcWrite = 1, instrDone = 1.
- `pcEn` = pcWrite | (branchEq & zero) | (branchNe & ~zero).
- opcode is sampled only in DECODE, MEMADR and BRANCH; it is ignored in all other states.
- Reset:
  - While reset = 1, all enables (irWrite, memWrite, regWrite, pcEn, instrDone, illegalOp) are forced to 0.
  - The edge with reset = 1 loads state = FETCH.
  - Mux selects during reset are don't-care and are driven 0.
- Reset asserted mid-instruction abandons that instruction. No partial write occurs after the reset edge.

## Timing
- The state register is the only sequential element. All outputs are combinational from state, reset, memReady, opcode and zero. There are no registered outputs.
- Cycles per instruction with memReady held at 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each cycle with memReady = 0 in FETCH, MEMRD or MEMWR adds one cycle. During such a wait, irWrite, memWrite and pcEn stay 0.
- pcEn in BRANCH is valid in the same cycle as zero. The PC updates at the edge that ends BRANCH.
- instrDone pulses exactly once per completed instruction.
- illegalOp pulses for the single DECODE cycle of an illegal opcode.
- The first FETCH begins in the cycle after reset deasserts.

## Test plan
- Reset, then lw with memReady = 1: states 0,1,2,3,4,0; regWrite = 1 and memToReg = 1 only in state 4; one instrDone pulse.
- sw with memReady low for 2 cycles in MEMWR: state 5 held 3 cycles; memWrite = 1 only in the third; total 6 cycles.
- beq with zero = 1 → pcEn = 1 in BRANCH. beq with zero = 0 → pcEn = 0. bne gives the inverse in both cases.
- R-type then addi back to back: regDst = 1 in ALUWB; regDst = 0 in ADDIWB; 4 cycles each; aluOp = 10 only in EXECUTE.
- opcode = 111111: illegalOp = 1 in DECODE, return to FETCH; 2 cycles total; no write enable asserted.
- Reset asserted during MEMRD: next state is FETCH; regWrite is never asserted; j afterwards: pcSrc = 10 and pcEn = 1 in JUMP, 3 cycles.
